demux_1x4_stream: RTL and testbench
===================================

# demux_1x4_stream

Registered 1-to-4 stream demultiplexer: the inverse of the 4x1 mux. Each beat on a single valid/ready input stream is routed by its 2-bit `select` tag into one of four independent output channels. Each channel has its own 2-entry FIFO, so a stalled channel blocks only beats addressed to it. The block sits between a shared producer and four consumers, and per-channel ordering is preserved.

## Interface
- `WIDTH`, default 32: data width of the input and of each output channel.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `in_data`  in  WIDTH  input payload.
- `select`  in  2  destination channel (0..3); sampled only when `in_valid`=1.
- `out_valid`  out  4  bit n: channel n head entry valid.
- `out_ready`  in  4  bit n: consumer n takes the head this cycle.
- `out0`..`out3`  out  WIDTH each  head payload of channels 0..3.

## Operation
- An input transfer occurs when `in_valid & in_ready` at a rising edge.
  - The beat is pushed into the FIFO of channel `select`.
  - No other channel changes.
- An output transfer on channel n occurs when `out_valid[n] & out_ready[n]`; it pops the head.
- `in_ready` = `~full[select]`.
  - It depends only on registered FIFO state and the current `select`.
  - There is no combinational path from `out_ready` to `in_ready`.
  - A full channel that is popping in the same cycle still refuses a push; the push is accepted one cycle later.
- Each channel FIFO is 2 entries deep, first-in first-out, with wrapping 1-bit read/write pointers and a 2-bit count.
  - Simultaneous push and pop on a channel with count 1 keeps count at 1; the new entry becomes head after the pop.
  - Simultaneous push and pop with count 0 is impossible, since `out_valid` is 0.
- `outN` shows the channel N head entry when `out_valid[N]`=1.
  - `outN` holds its last value when empty.
  - `outN` is stable while `out_valid[N] & ~out_ready[N]`.
- Upstream rule: `in_data` and `select` must stay stable while `in_valid & ~in_ready`.
  - Changing `select` while stalled is legal but redirects the beat.
  - The block neither detects nor reports this.
- Asserting `in_valid` with no transfer has no effect. `select` is ignored while `in_valid`=0.

## Timing
- Reset is asynchronous and takes effect immediately:
  - all FIFOs empty and pointers 0;
  - `out_valid`=4'b0000;
  - `out0`..`out3`=0;
  - `in_ready`=1 for any `select`.
- Latency: a beat accepted at edge k appears with `out_valid` high from edge k onward, i.e. visible in cycle k+1.
- Throughput: one beat per cycle into a channel whose consumer holds `out_ready`=1 continuously.
- Reset mid-operation discards all buffered beats. No partial outputs remain after `rst_n` falls.

## Structure
- Shared package `demux_pkg`:
  - `SEL_W`=2;
  - `NUM_CH`=4;
  - `FIFO_DEPTH`=2;
  - typedef `sel_t` (logic [SEL_W-1:0]).
- Sub-module `demux_fifo2` (params `WIDTH`):
  - ports `clk`, `rst_n`, `push`, `din`, `pop`, `dout`, `valid`, `full`;
  - instantiated 4 times.
- Top level contains only push decode, `in_ready` mux and output wiring.

## Test plan
- Reset with `rst_n`=0 mid-burst: `out_valid` goes to 0 immediately, `out0`..`out3`=0, and `in_ready`=1.
- Beats 0xA5A5A5A5 (sel=2) then 0x12345678 (sel=0), all `out_ready`=1:
  - `out2`=0xA5A5A5A5 with `out_valid`=4'b0100 in cycle k+1;
  - then `out0`=0x12345678 with `out_valid`=4'b0001;
  - other channels stay invalid.
- Three beats 1, 2, 3 to sel=1 with `out_ready[1]`=0:
  - `in_ready` drops after beat 2, and beat 3 stalls;
  - a beat to sel=3 during the stall is accepted;
  - raising `out_ready[1]` drains 1, 2, 3 in order.
- Channel 1 full and popping in the same cycle: `in_ready`=0 for sel=1 that cycle; the push is accepted the next cycle.
- Channel with count 1, simultaneous push(0xBEEF) and pop: count stays 1 and the head becomes 0xBEEF.
- 1000 random beats with random `select` and `out_ready`: the scoreboard per channel matches order and data, and no beat is lost or duplicated.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
// Imported by the interface, the channel FIFO and the top level.
package demux_pkg;

    localparam int SEL_W      = 2;
    localparam int NUM_CH     = 4;
    localparam int FIFO_DEPTH = 2;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/demux_1x4_stream_if.sv
// Handshake bundle between the shared producer, the demux and its
// four consumers; slave is the demux side, master the environment.
interface demux_1x4_stream_if
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    sel_t             select;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;

    modport slave (
        input  in_valid, in_data, select, out_ready,
        output in_ready, out_valid, out0, out1, out2, out3
    );

    modport master (
        output in_valid, in_data, select, out_ready,
        input  in_ready, out_valid, out0, out1, out2, out3
    );

endinterface

// File: rtl/demux_fifo2.sv
// Two-entry per-channel FIFO with 1-bit wrapping pointers.
// When empty, dout keeps showing the most recently popped entry.
module demux_fifo2
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != 2'd0);
    assign full    = (count == 2'(FIFO_DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & valid;

    // Storage, pointers and occupancy update on accepted push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    // Empty: the slot behind rd_ptr still holds the last popped beat.
    always_comb begin
        dout = valid ? mem[rd_ptr] : mem[~rd_ptr];
    end

endmodule

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demux: routes each input beat by select
// into one of four independent two-entry channel FIFOs.
module demux_1x4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    demux_1x4_stream_if.slave  bus
);

    sel_t              sel;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] vld;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic              accept;
    logic [WIDTH-1:0]  dout [NUM_CH];

    assign sel          = bus.select;
    assign accept       = bus.in_valid & ~full[sel];
    assign bus.in_ready = ~full[sel];
    assign bus.out_valid = vld;
    assign pop          = vld & bus.out_ready;

    // One-hot push decode from the select tag.
    always_comb begin
        push = '0;
        unique case (sel)
            2'd0:    push[0] = accept;
            2'd1:    push[1] = accept;
            2'd2:    push[2] = accept;
            default: push[3] = accept;
        endcase
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        demux_fifo2 #(
            .WIDTH (WIDTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .din   (bus.in_data),
            .pop   (pop[g]),
            .dout  (dout[g]),
            .valid (vld[g]),
            .full  (full[g])
        );
    end

    assign bus.out0 = dout[0];
    assign bus.out1 = dout[1];
    assign bus.out2 = dout[2];
    assign bus.out3 = dout[3];

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Self-checking bench for demux_1x4_stream: directed scenarios plus
// random traffic against a per-channel queue reference model.
module tb_demux_1x4_stream;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    logic [31:0] q [4][$];
    logic [31:0] last [4];

    demux_1x4_stream_if #(.WIDTH(32)) bus ();

    demux_1x4_stream #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_of(input int n);
        case (n)
            0:       return bus.out0;
            1:       return bus.out1;
            2:       return bus.out2;
            default: return bus.out3;
        endcase
    endfunction

    task automatic model_clear();
        for (int n = 0; n < 4; n++) begin
            q[n].delete();
            last[n] = '0;
        end
    endtask

    // Check DUT against the model, then advance one clock.
    task automatic tick();
        bit       acc;
        bit [3:0] pv;
        int       s;
        logic [31:0] d;
        #1;
        s   = int'(bus.select);
        d   = bus.in_data;
        acc = bus.in_valid && (q[s].size() < 2);
        chk("in_ready", 32'(bus.in_ready), 32'(q[s].size() < 2));
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("out_valid[%0d]", n), 32'(bus.out_valid[n]),
                32'(q[n].size() != 0));
            if (q[n].size() != 0)
                chk($sformatf("out%0d head", n), out_of(n), q[n][0]);
            else
                chk($sformatf("out%0d hold", n), out_of(n), last[n]);
            pv[n] = (q[n].size() != 0) && bus.out_ready[n];
        end
        @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) begin
            if (pv[n]) last[n] = q[n].pop_front();
        end
        if (acc) q[s].push_back(d);
    endtask

    task automatic chk_reset();
        chk("rst out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst out0", bus.out0, 32'h0);
        chk("rst out1", bus.out1, 32'h0);
        chk("rst out2", bus.out2, 32'h0);
        chk("rst out3", bus.out3, 32'h0);
        for (int s = 0; s < 4; s++) begin
            bus.select = 2'(s);
            #0;
            chk($sformatf("rst in_ready sel%0d", s),
                32'(bus.in_ready), 32'h1);
        end
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.select    = '0;
        bus.out_ready = 4'h0;
        model_clear();
        #2;
        chk_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        bus.out_ready = 4'hF;
        bus.in_valid  = 1'b1;
        bus.select    = 2'd2;
        bus.in_data   = 32'hA5A5A5A5;
        tick();
        chk("k+1 out_valid", 32'(bus.out_valid), 32'h4);
        chk("k+1 out2", bus.out2, 32'hA5A5A5A5);
        bus.select  = 2'd0;
        bus.in_data = 32'h12345678;
        tick();
        chk("2nd out_valid", 32'(bus.out_valid), 32'h1);
        chk("2nd out0", bus.out0, 32'h12345678);
        bus.in_valid = 1'b0;
        tick();
        chk("hold out0", bus.out0, 32'h12345678);

        bus.out_ready = 4'b1101;
        bus.in_valid  = 1'b1;
        bus.select    = 2'd1;
        bus.in_data   = 32'd1;
        tick();
        bus.in_data = 32'd2;
        tick();
        bus.in_data = 32'd3;
        #1;
        chk("ch1 full stall", 32'(bus.in_ready), 32'h0);
        tick();
        bus.select  = 2'd3;
        bus.in_data = 32'h33;
        #1;
        chk("sel3 during stall", 32'(bus.in_ready), 32'h1);
        tick();
        chk("sel3 accepted", 32'(bus.out_valid[3]), 32'h1);
        bus.select    = 2'd1;
        bus.in_data   = 32'd3;
        bus.out_ready = 4'hF;
        #1;
        chk("full+pop refuse", 32'(bus.in_ready), 32'h0);
        chk("drain head 1", bus.out1, 32'd1);
        tick();
        chk("drain head 2", bus.out1, 32'd2);
        chk("push next cycle", 32'(bus.in_ready), 32'h1);
        tick();
        chk("drain head 3", bus.out1, 32'd3);
        bus.in_valid = 1'b0;
        tick();
        chk("ch1 empty", 32'(bus.out_valid[1]), 32'h0);

        bus.out_ready = 4'h0;
        bus.in_valid  = 1'b1;
        bus.select    = 2'd0;
        bus.in_data   = 32'h11;
        tick();
        bus.out_ready = 4'h1;
        bus.in_data   = 32'hBEEF;
        tick();
        chk("push+pop valid", 32'(bus.out_valid[0]), 32'h1);
        chk("push+pop head", bus.out0, 32'hBEEF);
        bus.out_ready = 4'h0;
        bus.in_valid  = 1'b0;
        tick();
        chk("count stays 1", 32'(bus.out_valid[0]), 32'h1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hCAFE;
        #1;
        chk("count 1 not full", 32'(bus.in_ready), 32'h1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'hF;
        tick();
        tick();

        bus.out_ready = 4'h0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.select   = 2'($urandom_range(0, 3));
            bus.in_data  = $urandom;
            tick();
        end
        #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk_reset();
        @(posedge clk);
        #1;
        chk("held in reset", 32'(bus.out_valid), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.select    = 2'($urandom_range(0, 3));
            bus.in_data   = $urandom;
            bus.out_ready = 4'($urandom);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'hF;
        tick();
        tick();
        tick();
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("drained ch%0d", n), 32'(q[n].size()), 32'h0);
        end
        chk("final out_valid", 32'(bus.out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
